// File: rtl/pkt_prior_sched.sv
// -----------------------------------------------------------------------------
// pkt_prior_sched
//
// Strict-priority scheduler for a priority-tagged packet word stream.
// Each accepted word is sorted into one of NUM_CLASS per-class FIFOs
// (class = min(tag, NUM_CLASS) - 1). The non-empty class with the lowest
// index is issued to a registered valid/ready egress port. The ingress has
// no backpressure: words with tag 0, or words that target a full class,
// are dropped and counted.
//
// Optional feature: define PKT_PRIOR_SCHED_AGING_EN to add per-class age
// counters that force service of a starving class once its age reaches
// AGE_LIMIT. Without the macro the scheduler is pure strict priority.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/data/prior    ingress word (no ready)
//   out_valid/data/prior   registered egress word, accepted on out_ready
//   class_empty            registered per-class empty flags
//   drop_pulse             registered 1-cycle pulse per dropped word
//   drop_cnt               registered saturating drop counter
// -----------------------------------------------------------------------------
module pkt_prior_sched #(
  parameter int DWIDTH      = 32,
  parameter int PRIOR_WIDTH = 6,
  parameter int NUM_CLASS   = 8,
  parameter int CLASS_DEPTH = 4,
  parameter int AGE_LIMIT   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [DWIDTH-1:0]      in_data,
  input  logic [PRIOR_WIDTH-1:0] in_prior,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DWIDTH-1:0]      out_data,
  output logic [PRIOR_WIDTH-1:0] out_prior,
  output logic [NUM_CLASS-1:0]   class_empty,
  output logic                   drop_pulse,
  output logic [15:0]            drop_cnt
);

  localparam int PW = $clog2(CLASS_DEPTH);
  localparam int CW = $clog2(CLASS_DEPTH + 1);
  localparam int SW = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam int EW = PRIOR_WIDTH + DWIDTH;

  logic [EW-1:0]        mem_q    [NUM_CLASS][CLASS_DEPTH];
  logic [PW-1:0]        wr_ptr_q [NUM_CLASS];
  logic [PW-1:0]        wr_ptr_d [NUM_CLASS];
  logic [PW-1:0]        rd_ptr_q [NUM_CLASS];
  logic [PW-1:0]        rd_ptr_d [NUM_CLASS];
  logic [CW-1:0]        cnt_q    [NUM_CLASS];
  logic [CW-1:0]        cnt_d    [NUM_CLASS];

  logic                 out_valid_q;
  logic [DWIDTH-1:0]    out_data_q;
  logic [PRIOR_WIDTH-1:0] out_prior_q;
  logic [NUM_CLASS-1:0] class_empty_q;
  logic                 drop_pulse_q;
  logic [15:0]          drop_cnt_q;

  logic [SW-1:0]        push_cls_s;
  logic                 push_en_s;
  logic                 drop_s;
  logic [SW-1:0]        sel_s;
  logic                 any_s;
  logic                 load_en_s;
  logic                 pop_en_s;
  logic [EW-1:0]        head_s;
  logic [NUM_CLASS-1:0] push_vec_s;
  logic [NUM_CLASS-1:0] pop_vec_s;

`ifdef PKT_PRIOR_SCHED_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  logic [AW-1:0] age_q [1:NUM_CLASS-1];
  logic [AW-1:0] age_d [1:NUM_CLASS-1];
`endif

  // Map the ingress tag to a class; tags above NUM_CLASS share the last class.
  always_comb begin
    if (in_prior == '0) begin
      push_cls_s = '0;
    end else if (32'(in_prior) > 32'(NUM_CLASS)) begin
      push_cls_s = SW'(NUM_CLASS - 1);
    end else begin
      push_cls_s = SW'(in_prior - PRIOR_WIDTH'(1));
    end
  end

  // Accept or drop the ingress word; fullness uses start-of-cycle counts so a
  // same-cycle pop never rescues a word.
  always_comb begin
    push_en_s = in_valid && (in_prior != '0) &&
                (cnt_q[push_cls_s] != CW'(CLASS_DEPTH));
    drop_s    = in_valid && !push_en_s;
  end

  // Pick the class to pop: lowest non-empty index, optionally pre-empted by
  // the lowest-index class whose age has hit the limit.
  always_comb begin
    any_s = 1'b0;
    sel_s = '0;
    for (int c = NUM_CLASS - 1; c >= 0; c--) begin
      if (cnt_q[c] != '0) begin
        any_s = 1'b1;
        sel_s = SW'(c);
      end else begin
        any_s = any_s;
      end
    end
`ifdef PKT_PRIOR_SCHED_AGING_EN
    for (int c = NUM_CLASS - 1; c >= 1; c--) begin
      if ((cnt_q[c] != '0) && (age_q[c] >= AW'(AGE_LIMIT))) begin
        sel_s = SW'(c);
      end else begin
        sel_s = sel_s;
      end
    end
`endif
  end

  // The output register reloads whenever it is empty or being consumed.
  always_comb begin
    load_en_s = !out_valid_q || out_ready;
    pop_en_s  = load_en_s && any_s;
    head_s    = mem_q[sel_s][rd_ptr_q[sel_s]];
  end

  // One-hot push/pop strobes per class.
  always_comb begin
    push_vec_s = '0;
    pop_vec_s  = '0;
    if (push_en_s) begin
      push_vec_s[push_cls_s] = 1'b1;
    end else begin
      push_vec_s = '0;
    end
    if (pop_en_s) begin
      pop_vec_s[sel_s] = 1'b1;
    end else begin
      pop_vec_s = '0;
    end
  end

  // FIFO pointer and occupancy next-state; simultaneous push/pop keeps count.
  always_comb begin
    for (int c = 0; c < NUM_CLASS; c++) begin
      wr_ptr_d[c] = push_vec_s[c] ? wr_ptr_q[c] + PW'(1) : wr_ptr_q[c];
      rd_ptr_d[c] = pop_vec_s[c]  ? rd_ptr_q[c] + PW'(1) : rd_ptr_q[c];
      case ({push_vec_s[c], pop_vec_s[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + CW'(1);
        2'b01:   cnt_d[c] = cnt_q[c] - CW'(1);
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
  end

`ifdef PKT_PRIOR_SCHED_AGING_EN
  // Age grows on each higher-priority pop while waiting; clears when served
  // or empty, and saturates at the limit.
  always_comb begin
    for (int c = 1; c < NUM_CLASS; c++) begin
      if ((cnt_q[c] == '0) || pop_vec_s[c]) begin
        age_d[c] = '0;
      end else if (pop_en_s && (sel_s < SW'(c)) && (age_q[c] < AW'(AGE_LIMIT))) begin
        age_d[c] = age_q[c] + AW'(1);
      end else begin
        age_d[c] = age_q[c];
      end
    end
  end

  // Age counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 1; c < NUM_CLASS; c++) age_q[c] <= '0;
    end else begin
      for (int c = 1; c < NUM_CLASS; c++) age_q[c] <= age_d[c];
    end
  end
`endif

  // Word storage; contents need no reset because occupancy gates all reads.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      mem_q[push_cls_s][wr_ptr_q[push_cls_s]] <= {in_prior, in_data};
    end
  end

  // FIFO bookkeeping, output register, empty flags and drop accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_prior_q   <= '0;
      class_empty_q <= '1;
      drop_pulse_q  <= 1'b0;
      drop_cnt_q    <= 16'h0000;
    end else begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        wr_ptr_q[c]      <= wr_ptr_d[c];
        rd_ptr_q[c]      <= rd_ptr_d[c];
        cnt_q[c]         <= cnt_d[c];
        class_empty_q[c] <= (cnt_d[c] == '0);
      end
      if (load_en_s) begin
        out_valid_q <= any_s;
        if (any_s) begin
          out_prior_q <= head_s[EW-1:DWIDTH];
          out_data_q  <= head_s[DWIDTH-1:0];
        end
      end
      drop_pulse_q <= drop_s;
      if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'h0001;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_prior   = out_prior_q;
  assign class_empty = class_empty_q;
  assign drop_pulse  = drop_pulse_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_pkt_prior_sched.sv
// -----------------------------------------------------------------------------
// Bench for pkt_prior_sched: a table of hand-derived vectors, hand-written
// sequences for the aging and mid-stream reset cases, then random traffic
// compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_pkt_prior_sched;

  localparam int TB_AGE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [5:0]  in_prior;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_prior;
  logic [7:0]  class_empty;
  logic        drop_pulse;
  logic [15:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  pkt_prior_sched #(
    .DWIDTH(32), .PRIOR_WIDTH(6), .NUM_CLASS(8), .CLASS_DEPTH(4), .AGE_LIMIT(TB_AGE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_prior(in_prior),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_prior(out_prior),
    .class_empty(class_empty), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [37:0] mq [8][$];
  bit          m_ov;
  logic [31:0] m_od;
  logic [5:0]  m_op;
  bit          m_dp;
  int          m_dcnt;
  int          m_age [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < 8; c++) begin
      mq[c].delete();
      m_age[c] = 0;
    end
    m_ov = 0; m_od = '0; m_op = '0; m_dp = 0; m_dcnt = 0;
  endtask

  task automatic m_step(input bit v, input logic [31:0] d, input logic [5:0] p, input bit rdy);
    int sz [8];
    int sel, cls, pi;
    bit drop;
    logic [37:0] e;
    for (int c = 0; c < 8; c++) sz[c] = mq[c].size();
    drop = 0; cls = -1; pi = int'(p);
    if (v) begin
      if (pi == 0) drop = 1;
      else begin
        cls = ((pi > 8) ? 8 : pi) - 1;
        if (sz[cls] >= 4) begin drop = 1; cls = -1; end
      end
    end
    sel = -1;
    if (!m_ov || rdy) begin
      for (int c = 7; c >= 0; c--) if (sz[c] > 0) sel = c;
`ifdef PKT_PRIOR_SCHED_AGING_EN
      for (int c = 7; c >= 1; c--) if (sz[c] > 0 && m_age[c] >= TB_AGE) sel = c;
`endif
      if (sel >= 0) begin
        e = mq[sel].pop_front();
        m_ov = 1; m_op = e[37:32]; m_od = e[31:0];
      end else m_ov = 0;
    end
`ifdef PKT_PRIOR_SCHED_AGING_EN
    for (int c = 1; c < 8; c++) begin
      if (sz[c] == 0 || sel == c) m_age[c] = 0;
      else if (sel >= 0 && sel < c && m_age[c] < TB_AGE) m_age[c]++;
    end
`endif
    if (cls >= 0) mq[cls].push_back({p, d});
    m_dp = drop;
    if (drop && m_dcnt < 65535) m_dcnt++;
  endtask

  task automatic cmp_model();
    logic [7:0] ce;
    for (int c = 0; c < 8; c++) ce[c] = (mq[c].size() == 0);
    chk("m_out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("m_out_data", out_data, m_od);
      chk("m_out_prior", out_prior, m_op);
    end
    chk("m_class_empty", class_empty, ce);
    chk("m_drop_pulse", drop_pulse, m_dp);
    chk("m_drop_cnt", drop_cnt, m_dcnt);
  endtask

  // One clock: drive inputs, advance model with the same inputs, check after edge.
  task automatic cyc(input bit v, input logic [31:0] d, input logic [5:0] p, input bit rdy);
    in_valid = v; in_data = d; in_prior = p; out_ready = rdy;
    @(posedge clk);
    m_step(v, d, p, rdy);
    #1;
    cmp_model();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, 32'h0);
    chk({tag, "_out_prior"}, out_prior, 6'h0);
    chk({tag, "_class_empty"}, class_empty, 8'hFF);
    chk({tag, "_drop_pulse"}, drop_pulse, 1'b0);
    chk({tag, "_drop_cnt"}, drop_cnt, 16'h0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic v; logic [31:0] d; logic [5:0] p; logic rdy;
    logic e_ov; logic [31:0] e_d; logic [5:0] e_p; logic e_dp; logic [15:0] e_dcnt; logic [7:0] e_ce;
  } vec_t;

  vec_t tbl [26];

  initial begin
    int n1;
    bit seen;
    bit v, rdy;
    int thr;

    tbl[0]  = '{1'b1, 32'hA5A5_0001, 6'd3,  1'b1, 1'b0, 32'h0, 6'd0,  1'b0, 16'd0, 8'hFB};
    tbl[1]  = '{1'b0, 32'h0,  6'd0,  1'b1, 1'b1, 32'hA5A5_0001, 6'd3, 1'b0, 16'd0, 8'hFF};
    tbl[2]  = '{1'b0, 32'h0,  6'd0,  1'b1, 1'b0, 32'h0, 6'd0,  1'b0, 16'd0, 8'hFF};
    tbl[3]  = '{1'b1, 32'h1,  6'd5,  1'b0, 1'b0, 32'h0, 6'd0,  1'b0, 16'd0, 8'hEF};
    tbl[4]  = '{1'b1, 32'h2,  6'd2,  1'b0, 1'b1, 32'h1, 6'd5,  1'b0, 16'd0, 8'hFD};
    tbl[5]  = '{1'b1, 32'h3,  6'd5,  1'b0, 1'b1, 32'h1, 6'd5,  1'b0, 16'd0, 8'hED};
    tbl[6]  = '{1'b0, 32'h0,  6'd0,  1'b0, 1'b1, 32'h1, 6'd5,  1'b0, 16'd0, 8'hED};
    tbl[7]  = '{1'b0, 32'h0,  6'd0,  1'b1, 1'b1, 32'h2, 6'd2,  1'b0, 16'd0, 8'hEF};
    tbl[8]  = '{1'b0, 32'h0,  6'd0,  1'b1, 1'b1, 32'h3, 6'd5,  1'b0, 16'd0, 8'hFF};
    tbl[9]  = '{1'b0, 32'h0,  6'd0,  1'b1, 1'b0, 32'h0, 6'd0,  1'b0, 16'd0, 8'hFF};
    tbl[10] = '{1'b1, 32'h20, 6'd2,  1'b0, 1'b0, 32'h0, 6'd0,  1'b0, 16'd0, 8'hFD};
    tbl[11] = '{1'b1, 32'h11, 6'd1,  1'b0, 1'b1, 32'h20, 6'd2, 1'b0, 16'd0, 8'hFE};
    tbl[12] = '{1'b1, 32'h12, 6'd1,  1'b0, 1'b1, 32'h20, 6'd2, 1'b0, 16'd0, 8'hFE};
    tbl[13] = '{1'b1, 32'h13, 6'd1,  1'b0, 1'b1, 32'h20, 6'd2, 1'b0, 16'd0, 8'hFE};
    tbl[14] = '{1'b1, 32'h14, 6'd1,  1'b0, 1'b1, 32'h20, 6'd2, 1'b0, 16'd0, 8'hFE};
    tbl[15] = '{1'b1, 32'h15, 6'd1,  1'b0, 1'b1, 32'h20, 6'd2, 1'b1, 16'd1, 8'hFE};
    tbl[16] = '{1'b1, 32'h16, 6'd1,  1'b0, 1'b1, 32'h20, 6'd2, 1'b1, 16'd2, 8'hFE};
    tbl[17] = '{1'b1, 32'h99, 6'd0,  1'b0, 1'b1, 32'h20, 6'd2, 1'b1, 16'd3, 8'hFE};
    tbl[18] = '{1'b0, 32'h0,  6'd0,  1'b1, 1'b1, 32'h11, 6'd1, 1'b0, 16'd3, 8'hFE};
    tbl[19] = '{1'b0, 32'h0,  6'd0,  1'b1, 1'b1, 32'h12, 6'd1, 1'b0, 16'd3, 8'hFE};
    tbl[20] = '{1'b0, 32'h0,  6'd0,  1'b1, 1'b1, 32'h13, 6'd1, 1'b0, 16'd3, 8'hFE};
    tbl[21] = '{1'b0, 32'h0,  6'd0,  1'b1, 1'b1, 32'h14, 6'd1, 1'b0, 16'd3, 8'hFF};
    tbl[22] = '{1'b0, 32'h0,  6'd0,  1'b1, 1'b0, 32'h0, 6'd0,  1'b0, 16'd3, 8'hFF};
    tbl[23] = '{1'b1, 32'h14, 6'd20, 1'b1, 1'b0, 32'h0, 6'd0,  1'b0, 16'd3, 8'h7F};
    tbl[24] = '{1'b0, 32'h0,  6'd0,  1'b1, 1'b1, 32'h14, 6'd20, 1'b0, 16'd3, 8'hFF};
    tbl[25] = '{1'b0, 32'h0,  6'd0,  1'b1, 1'b0, 32'h0, 6'd0,  1'b0, 16'd3, 8'hFF};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_prior = '0; out_ready = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 26; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].p, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_d);
        chk($sformatf("tbl%0d_prior", i), out_prior, tbl[i].e_p);
      end
      chk($sformatf("tbl%0d_drop_pulse", i), drop_pulse, tbl[i].e_dp);
      chk($sformatf("tbl%0d_drop_cnt", i), drop_cnt, tbl[i].e_dcnt);
      chk($sformatf("tbl%0d_class_empty", i), class_empty, tbl[i].e_ce);
    end

    // Starvation: class 0 kept busy while one prior=8 word waits.
    cyc(1'b1, 32'h100, 6'd1, 1'b0);
    cyc(1'b1, 32'h101, 6'd1, 1'b0);
    cyc(1'b1, 32'h102, 6'd1, 1'b0);
    cyc(1'b1, 32'h800, 6'd8, 1'b0);
    n1 = 0; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc(1'b1, 32'h200 + k, 6'd1, 1'b1);
      if (out_valid && out_data == 32'h800) seen = 1;
      else if (out_valid && out_prior == 6'd1) n1++;
    end
`ifdef PKT_PRIOR_SCHED_AGING_EN
    chk("aging_served", seen, 1'b1);
    chk("aging_grants", n1, 4);
`else
    chk("strict_starved", seen, 1'b0);
`endif
    repeat (12) cyc(1'b0, 32'h0, 6'd0, 1'b1);

    // Mid-stream asynchronous reset with words stored.
    cyc(1'b1, 32'hDEAD_0001, 6'd2, 1'b0);
    cyc(1'b1, 32'hDEAD_0002, 6'd4, 1'b0);
    cyc(1'b1, 32'hDEAD_0003, 6'd0, 1'b0);
    cyc(1'b1, 32'hDEAD_0004, 6'd6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    m_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 32'h0, 6'd0, 1'b1);
      chk($sformatf("no_stale%0d", k), out_valid, 1'b0);
    end

    // Random traffic against the model, alternating light and heavy backpressure.
    for (int i = 0; i < 3000; i++) begin
      thr = ((i / 300) % 2 == 1) ? 25 : 85;
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 99) < thr);
      cyc(v, $urandom, 6'($urandom_range(0, 12)), rdy);
    end
    repeat (40) cyc(1'b0, 32'h0, 6'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
